mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single off-chip memory port (256b line, enable/write/ack handshake) between two
//  line-fill requesters: port 0 = instruction-side cache, port 1 = dcache. Sits between the CPU's
//  cache masters and the external memory model. Round-robin grant, one transaction in flight,
//  registered request path, combinational ack/data return.
// PARAMETERS
//  ADDR_W      32    memory address width
//  DATA_W      256   cache line width
//  TIMEOUT     1024  BUSY cycles without mem_ack_i before timeout_o sets; 0 disables watchdog
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  rst_i          in   1       reset, synchronous, active-high
//  m{0,1}_enable_i in  1       requester holds high until its ack
//  m{0,1}_write_i in   1       1 = line write-back, 0 = line fill
//  m{0,1}_addr_i  in   ADDR_W  line address
//  m{0,1}_data_i  in   DATA_W  write-back data
//  m{0,1}_ack_o   out  1       one-cycle ack, only to current owner
//  m{0,1}_data_o  out  DATA_W  read data, = mem_data_i on both ports (qualified by ack)
//  mem_enable_o   out  1       registered request to memory
//  mem_write_o    out  1       registered write flag
//  mem_addr_o     out  ADDR_W  registered address
//  mem_data_o     out  DATA_W  registered write data
//  mem_data_i     in   DATA_W  memory read data
//  mem_ack_i      in   1       memory completion pulse
//  owner_o        out  1       current/last owner index
//  err_ack_o      out  1       sticky: mem_ack_i seen outside BUSY
//  timeout_o      out  1       sticky: watchdog expired
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state=IDLE, last=1 (port 0 wins first tie), owner_o=0, wdog=0,
//   mem_enable_o/mem_write_o=0, mem_addr_o/mem_data_o=0, err_ack_o=timeout_o=0. Reset during
//   BUSY aborts: mem_enable_o low after that edge; memory must be reset in the same cycle.
//  FSM: IDLE -> BUSY -> TURN -> IDLE.
//  IDLE: if any m*_enable_i: pick sole requester, or if both, the one != last. At edge: owner=pick,
//   mem_enable_o=1, latch pick's write/addr/data into mem_* regs, wdog=0, state=BUSY.
//   Request visible in cycle N -> mem_enable_o high in N+1 (1-cycle grant latency).
//  BUSY: mem_* regs held constant (requester changes ignored). mem_ack_i=1 -> m<owner>_ack_o=1 same
//   cycle (combinational), other ack 0; at edge mem_enable_o=0, last=owner, state=TURN.
//   Else wdog++ (saturating ADDR_W-independent 16b); wdog==TIMEOUT-1 and TIMEOUT!=0 -> timeout_o=1;
//   transaction keeps waiting (no abort).
//  TURN: one dead cycle, no requests sampled (owner drops enable here); -> IDLE.
//  Non-owner requests during BUSY/TURN wait; no starvation: alternate owners under continuous load,
//   max wait = one foreign transaction + 2 cycles + grant latency.
//  mem_ack_i in IDLE/TURN: ignored for acks, err_ack_o=1 until reset.
//  m*_ack_o never asserted outside BUSY; never both high.
// STRUCTURE
//  mem_arb_pkg: state enum {IDLE,BUSY,TURN}, ADDR_W/DATA_W defaults, WDOG_W=16.
//  Sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last -> gnt_valid, idx).
//  Top: FSM, latched request regs, watchdog counter, ack/data return muxing.
// TESTING
//  Single m1 read, addr 0x0000_0400, mem acks 10 cycles later -> mem_enable_o rises 1 cycle after
//   request, m1_ack_o one cycle with data, m0_ack_o stays 0, mem_enable_o low next cycle.
//  m0 and m1 request same cycle after reset -> m0 granted first; after ack+TURN m1 granted; third
//   round with both held -> m0 again (strict alternation).
//  m1 write addr 0x80 data 0xAA..AA; m1 changes addr to 0xC0 mid-BUSY -> mem_addr_o stays 0x80,
//   mem_write_o=1 until ack.
//  mem_ack_i pulsed while IDLE -> no m*_ack_o, err_ack_o=1 and holds until rst_i.
//  TIMEOUT=8, no ack for 20 cycles -> timeout_o=1 after 8 BUSY cycles, mem_enable_o still high;
//   late ack completes normally. rst_i mid-BUSY -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 256;
    localparam int WDOG_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the port
// that was not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       idx
);
    always_comb begin
        gnt_valid = |req;
        idx       = 1'b0;
        if (req == 2'b11) begin
            idx = ~last;
        end else begin
            idx = req[1];
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the icache (port 0) and dcache
// (port 1); one transaction in flight, registered request, combinational ack.
//
// state | meaning
// IDLE  | waiting for a requester; grant taken at the next edge
// BUSY  | request on the memory port, waiting for mem_ack_i
// TURN  | dead cycle so the served owner can drop its enable
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              owner_o,
    output logic              err_ack_o,
    output logic              timeout_o
);
    localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(TIMEOUT - 1);

    arb_state_e        state_r;
    arb_state_e        state_nxt;
    logic              last_r;
    logic              owner_r;
    logic [WDOG_W-1:0] wdog_r;
    logic              gnt_valid;
    logic              pick;

    rr_pick2 u_pick (
        .req       ({m1_enable_i, m0_enable_i}),
        .last      (last_r),
        .gnt_valid (gnt_valid),
        .idx       (pick)
    );

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:    if (gnt_valid) state_nxt = BUSY;
            BUSY:    if (mem_ack_i) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_r       <= 1'b1;
            owner_r      <= 1'b0;
            wdog_r       <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            err_ack_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            if (mem_ack_i && (state_r != BUSY)) begin
                err_ack_o <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_r      <= pick;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= pick ? m1_write_i : m0_write_i;
                        mem_addr_o   <= pick ? m1_addr_i  : m0_addr_i;
                        mem_data_o   <= pick ? m1_data_i  : m0_data_i;
                        wdog_r       <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        last_r       <= owner_r;
                    end else begin
                        if (wdog_r != '1) begin
                            wdog_r <= wdog_r + 1'b1;
                        end
                        // Watchdog only flags; the transaction keeps waiting.
                        if ((TIMEOUT != 0) && (wdog_r == WDOG_TC)) begin
                            timeout_o <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_ack_o  = (state_r == BUSY) && mem_ack_i && !owner_r;
    assign m1_ack_o  = (state_r == BUSY) && mem_ack_i &&  owner_r;
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;
    assign owner_o   = owner_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both caches and the
// memory; acks are checked by a scoreboard monitor on the falling edge.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i;
    logic          m0_ack_o, m1_ack_o;
    logic [DW-1:0] m0_data_o, m1_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i;
    logic          mem_ack_i;
    logic          owner_o, err_ack_o, timeout_o;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .owner_o(owner_o), .err_ack_o(err_ack_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
        mem_ack_i   = 1'b0; mem_data_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Memory completion: ack this cycle with the given data, expecting it on port p.
    task automatic mem_ack(input bit p, input logic [DW-1:0] d);
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        exp_q.push_back('{port: p, data: d});
        tick();
        mem_ack_i = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        if (m0_ack_o || m1_ack_o) begin
            n_checks++;
            if (m0_ack_o && m1_ack_o) begin
                n_fail++;
                $display("FAIL both_acks: m0_ack=%b m1_ack=%b expected at most one", m0_ack_o, m1_ack_o);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b expected none", m0_ack_o, m1_ack_o);
            end else begin
                exp_t e;
                logic [DW-1:0] d;
                e = exp_q.pop_front();
                d = m1_ack_o ? m1_data_o : m0_data_o;
                if ((e.port != m1_ack_o) || (d !== e.data)) begin
                    n_fail++;
                    $display("FAIL ack_port_data: got port %0d data %h expected port %0d data %h",
                             m1_ack_o, d, e.port, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d0, d1, d2, aa, pat55;
        d0    = {8{32'hDEAD_0001}};
        d1    = {8{32'hBEEF_0002}};
        d2    = {8{32'hCAFE_0003}};
        aa    = {32{8'hAA}};
        pat55 = {32{8'h55}};

        // Reset values
        do_reset();
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_err_ack", err_ack_o, 0);
        chk("rst_timeout", timeout_o, 0);

        // Single m1 read, ack 10 cycles into BUSY
        m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h0000_0400;
        chk("t1_enable_latency0", mem_enable_o, 0);
        tick();
        chk("t1_enable_rise", mem_enable_o, 1);
        chk("t1_addr", mem_addr_o, 32'h400);
        chk("t1_owner", owner_o, 1);
        chk("t1_write", mem_write_o, 0);
        repeat (9) tick();
        mem_ack(1'b1, d0);
        m1_enable_i = 1'b0;
        chk("t1_enable_fall", mem_enable_o, 0);
        tick();
        tick();

        // Both request after reset: strict alternation 0, 1, 0
        do_reset();
        m0_enable_i = 1'b1; m0_addr_i = 32'h100;
        m1_enable_i = 1'b1; m1_addr_i = 32'h200;
        tick();
        chk("t2_first_owner", owner_o, 0);
        chk("t2_first_addr", mem_addr_o, 32'h100);
        tick();
        mem_ack(1'b0, d0);
        m0_enable_i = 1'b0;
        chk("t2_turn_enable", mem_enable_o, 0);
        tick();
        chk("t2_idle_enable", mem_enable_o, 0);
        tick();
        chk("t2_second_owner", owner_o, 1);
        chk("t2_second_addr", mem_addr_o, 32'h200);
        m0_enable_i = 1'b1;
        tick();
        mem_ack(1'b1, d1);
        tick();
        tick();
        tick();
        chk("t2_third_owner", owner_o, 0);
        chk("t2_third_addr", mem_addr_o, 32'h100);
        mem_ack(1'b0, d2);
        m0_enable_i = 1'b0; m1_enable_i = 1'b0;
        tick();
        tick();

        // m1 write-back; request changes mid-BUSY are ignored
        do_reset();
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h80; m1_data_i = aa;
        tick();
        m1_addr_i = 32'hC0; m1_data_i = pat55; m1_write_i = 1'b0;
        tick();
        tick();
        chk("t3_addr_held", mem_addr_o, 32'h80);
        chk("t3_write_held", mem_write_o, 1);
        chk("t3_data_held", mem_data_o, aa);
        mem_ack(1'b1, d1);
        m1_enable_i = 1'b0;
        chk("t3_enable_fall", mem_enable_o, 0);
        tick();
        tick();

        // Stray ack while idle
        do_reset();
        chk("t4_err_before", err_ack_o, 0);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("t4_err_set", err_ack_o, 1);
        repeat (3) tick();
        chk("t4_err_sticky", err_ack_o, 1);
        do_reset();
        chk("t4_err_cleared", err_ack_o, 0);

        // Watchdog with TIMEOUT=8, late ack still completes
        m0_enable_i = 1'b1; m0_addr_i = 32'h300;
        tick();
        repeat (7) tick();
        chk("t5_timeout_pre", timeout_o, 0);
        tick();
        chk("t5_timeout_set", timeout_o, 1);
        chk("t5_enable_held", mem_enable_o, 1);
        repeat (12) tick();
        mem_ack(1'b0, d2);
        m0_enable_i = 1'b0;
        chk("t5_enable_fall", mem_enable_o, 0);
        chk("t5_timeout_sticky", timeout_o, 1);
        tick();
        tick();

        // Reset in the middle of BUSY
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h440; m1_data_i = aa;
        tick();
        tick();
        chk("t6_busy_enable", mem_enable_o, 1);
        rst_i = 1'b1; m1_enable_i = 1'b0;
        tick();
        rst_i = 1'b0;
        chk("t6_rst_enable", mem_enable_o, 0);
        chk("t6_rst_write", mem_write_o, 0);
        chk("t6_rst_addr", mem_addr_o, 0);
        chk("t6_rst_data", mem_data_o, 0);
        chk("t6_rst_owner", owner_o, 0);
        chk("t6_rst_timeout", timeout_o, 0);
        m0_enable_i = 1'b1; m0_addr_i = 32'h500;
        m1_enable_i = 1'b1; m1_addr_i = 32'h600;
        tick();
        chk("t6_regrant_owner", owner_o, 0);
        chk("t6_regrant_addr", mem_addr_o, 32'h500);
        mem_ack(1'b0, d1);
        m0_enable_i = 1'b0; m1_enable_i = 1'b0;
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
